pixel_writeback: RTL
====================

// Module: pixel_writeback
// PURPOSE
//  Downstream stage of the watermark soft processor.
//  Samples the processor's output pixel (regout[11:0]) each time the pixel index (counter) advances.
//  Buffers {index, pixel} pairs in a small FIFO and drains them to the VGA frame buffer's write port over a valid/ready handshake.
//  Flags frame completion and FIFO overflow.
// PARAMETERS
//  PIX_W    12    pixel width (4:4:4 RGB)
//  ADDR_W   12    index / frame-buffer address width
//  DEPTH    8     FIFO entries; power of two, >= 2
//  NUM_PIX  4096  pixels per frame; last address = NUM_PIX-1
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  index       in   ADDR_W  processor pixel counter
//  regout_pix  in   PIX_W   processor result pixel for index
//  flush       in   1       level; stop capture, drain FIFO
//  fb_valid    out  1       write request to frame buffer
//  fb_ready    in   1       frame buffer accepts when high with fb_valid
//  fb_addr     out  ADDR_W  write address (head entry index)
//  fb_data     out  PIX_W   write data (head entry pixel)
//  frame_done  out  1       1-cycle pulse: addr NUM_PIX-1 accepted
//  overflow    out  1       sticky: a capture was dropped
//  flushed     out  1       level: in DONE state
//  level       out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset, synchronous active-high, on clk rising edge:
//  - Outputs fb_valid, frame_done, overflow, flushed and level = 0.
//  - fb_addr and fb_data = 0.
//  - FSM = RUN; seen = 0; last_index = 0.
//  - Reset mid-transfer discards all FIFO contents.
//  Capture event (RUN only): cap = (!seen || index != last_index).
//  - On cap: last_index <= index; seen <= 1.
//  - Push {index, regout_pix} sampled that same edge.
//  Push rules:
//  - If FIFO not full, or a pop occurs in the same cycle: push.
//  - Otherwise drop the sample and set overflow <= 1.
//  - overflow is cleared only by reset.
//  Pop: fb_valid && fb_ready at the edge.
//  - Head advances; level decrements, unless a push occurs in the same cycle.
//  FIFO is first-word-fall-through:
//  - fb_valid = (level != 0); fb_addr/fb_data show the head entry combinationally from registers.
//  - No bypass: a capture into an empty FIFO gives fb_valid on the following cycle (latency 1).
//  - fb_addr and fb_data hold stable while fb_valid && !fb_ready.
//  Pointers are ADDR $clog2(DEPTH) bits and wrap modulo DEPTH. level counts 0..DEPTH.
//  frame_done: registered; high the cycle after a pop whose addr == NUM_PIX-1.
//  Index wrap (NUM_PIX-1 -> 0) is a normal capture; no special handling.
//  FSM:
//  - RUN:   capture enabled; flush=1 -> FLUSH.
//  - FLUSH: no capture; pops continue; level==0 (incl. after last pop) -> DONE.
//  - DONE:  flushed=1; flush=0 -> RUN with seen<=0, so the next index is always captured.
//  - flush deasserted while in FLUSH -> RUN; seen is retained.
//  Simultaneous cap + flush rising in RUN: that cycle still captures, since the transition takes effect next cycle.
// STRUCTURE
//  Shared package (pixel_pkg): PIX_W, ADDR_W, NUM_PIX constants; FSM state localparams RUN=2'd0, FLUSH=2'd1, DONE=2'd2.
//  One sub-module: wb_fifo (sync FWFT FIFO, DEPTH x (ADDR_W+PIX_W)).
//  - Ports: push, pop, din, dout, level, full, empty.
//  Top level holds change-detect, FSM, overflow and frame_done logic.
// TESTING
//  1. Reset, then index 0..3 with pix 0xF00, 0x0F0, 0x00F, 0xFFF; fb_ready=1.
//     -> 4 writes in order, addr 0..3, each 1 cycle after capture; overflow=0.
//  2. Index held at 5 for 10 cycles.
//     -> exactly one write, addr 5.
//  3. fb_ready=0; 10 distinct indices, DEPTH=8.
//     -> level=8; overflow=1 after the 9th; release gives 8 writes, the first 8 indices.
//  4. Full FIFO, fb_ready=1, new index in the same cycle.
//     -> pop and push both occur; level stays 8; overflow stays 0.
//  5. Index 4094, 4095, 0 with fb_ready=1.
//     -> frame_done pulses once, the cycle after addr 4095 is accepted.
//  6. 3 entries queued, flush=1, fb_ready toggling; then assert reset while 1 entry remains.
//     -> no new captures; flushed=1 when empty; reset clears fb_valid and level to 0 next edge.

Source files
------------

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants and FSM encodings for the pixel writeback stage
package pixel_pkg;

  // Pixel format and frame geometry of the VGA frame buffer
  localparam int PIX_W   = 12;
  localparam int ADDR_W  = 12;
  localparam int NUM_PIX = 4096;
  localparam int DEPTH   = 8;

  // Writeback FSM encodings
  typedef logic [1:0] wb_state_t;
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous first-word-fall-through FIFO for {index, pixel} entries
module wb_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             pop_ok;
  logic             push_ok;

  // A pop is only honoured when there is something to pop; a push into a
  // full FIFO is only honoured when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);
  assign dout  = mem[head];

  // Storage array; contents are don't-care until the level says otherwise
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= din;
    end
  end

  // Pointers and occupancy; reset discards everything queued
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (pop_ok) begin
        head <= head + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writeback.sv
// rtl/pixel_writeback.sv - captures processor pixels on index change and drains them to the frame buffer
module pixel_writeback
  import pixel_pkg::*;
#(
  parameter int PIX_W   = pixel_pkg::PIX_W,
  parameter int ADDR_W  = pixel_pkg::ADDR_W,
  parameter int DEPTH   = pixel_pkg::DEPTH,
  parameter int NUM_PIX = pixel_pkg::NUM_PIX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         index,
  input  logic [PIX_W-1:0]          regout_pix,
  input  logic                      flush,
  output logic                      fb_valid,
  input  logic                      fb_ready,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [PIX_W-1:0]          fb_data,
  output logic                      frame_done,
  output logic                      overflow,
  output logic                      flushed,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int ENT_W = ADDR_W + PIX_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  wb_state_t           state;
  wb_state_t           state_next;
  logic                seen;
  logic [ADDR_W-1:0]   last_index;
  logic                cap;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENT_W-1:0]    head_entry;
  logic [LVL_W-1:0]    level_next;

  // A new sample is taken whenever the pixel counter moves, or on the very
  // first index after reset / after leaving DONE.
  assign cap  = (state == RUN) && (!seen || (index != last_index));
  assign pop  = fb_valid && fb_ready;
  assign push = cap && (!fifo_full || pop);

  wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({index, regout_pix}),
    .dout  (head_entry),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head entry is shown directly; an empty FIFO presents zeros so the
  // bus is quiet after reset and between bursts.
  assign fb_valid = !fifo_empty;
  assign fb_addr  = fifo_empty ? '0 : head_entry[ENT_W-1 -: ADDR_W];
  assign fb_data  = fifo_empty ? '0 : head_entry[PIX_W-1:0];
  assign flushed  = (state == DONE);

  // Occupancy after this edge, used to leave FLUSH on the last pop itself
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Next-state logic: flush level steers RUN/FLUSH, DONE waits for flush release
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (flush) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!flush) begin
          state_next = RUN;
        end else if (level_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!flush) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Change-detect history; leaving DONE forgets it so capture restarts cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      seen       <= 1'b0;
      last_index <= '0;
    end else if ((state == DONE) && !flush) begin
      seen <= 1'b0;
    end else if (cap) begin
      seen       <= 1'b1;
      last_index <= index;
    end
  end

  // Sticky drop flag: a capture arrived while full with no pop to make room
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (cap && !push) begin
      overflow <= 1'b1;
    end
  end

  // One-cycle pulse after the last pixel of the frame is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && (fb_addr == LAST_ADDR);
    end
  end

endmodule
